// File: rtl/sdram_pkg.sv
// sdram_pkg: shared types and helpers for the SDRAM CPU bridge.
//   - bridge_state_e : bridge FSM states
//   - WORD_AW/BYTE_AW: SDRAM word address / CPU byte address widths
//   - lane_ds        : byte-lane enable from address bit 0
//   - byte_extract   : pick one byte out of a 16-bit word
//   - byte_merge     : replace one byte of a 16-bit word
package sdram_pkg;

  localparam int WORD_AW = 23;
  localparam int BYTE_AW = WORD_AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } bridge_state_e;

  // Little-endian: even byte address lives in the low byte of the word.
  function automatic logic [1:0] lane_ds(input logic a0);
    return a0 ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [7:0] byte_extract(input logic [15:0] word, input logic a0);
    return a0 ? word[15:8] : word[7:0];
  endfunction

  function automatic logic [15:0] byte_merge(input logic [15:0] word, input logic a0,
                                             input logic [7:0] b);
    return a0 ? {b, word[7:0]} : {word[15:8], b};
  endfunction

endpackage

// File: rtl/sdram_cpu_bridge_if.sv
// sdram_cpu_bridge_if: one port of the SDRAM controller, toggle req/ack protocol.
//   mem_req  : toggles to start an access (bridge -> controller)
//   mem_ack  : equals mem_req once the access is done (controller -> bridge)
//   mem_we   : 1 = write
//   mem_a    : word address
//   mem_ds   : byte enables, ds[0] = low byte
//   mem_d    : write data
//   mem_q    : read data, valid in the cycle mem_ack == mem_req
// Modports: master = bridge side, slave = controller side.
interface sdram_cpu_bridge_if;
  import sdram_pkg::*;

  logic               mem_req;
  logic               mem_ack;
  logic               mem_we;
  logic [WORD_AW-1:0] mem_a;
  logic [1:0]         mem_ds;
  logic [15:0]        mem_d;
  logic [15:0]        mem_q;

  modport master (
    output mem_req, mem_we, mem_a, mem_ds, mem_d,
    input  mem_ack, mem_q
  );

  modport slave (
    input  mem_req, mem_we, mem_a, mem_ds, mem_d,
    output mem_ack, mem_q
  );
endinterface

// File: rtl/sdram_word_cache.sv
// sdram_word_cache: one-word read cache (tag, valid, 16-bit line).
//   clk, reset   : clock, synchronous active-high reset (clears valid only)
//   lookup_tag   : word address to compare against the stored tag
//   flush        : clears valid next cycle, wins over a same-cycle fill,
//                  and forces a miss in the current cycle
//   fill_en/...  : load a whole line from SDRAM read data
//   merge_en/... : write-through merge of one byte into the line
//   hit          : lookup hit
//   line         : current line contents
module sdram_word_cache
  import sdram_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WORD_AW-1:0] lookup_tag,
  input  logic               flush,
  input  logic               fill_en,
  input  logic [WORD_AW-1:0] fill_tag,
  input  logic [15:0]        fill_data,
  input  logic               merge_en,
  input  logic               merge_a0,
  input  logic [7:0]         merge_byte,
  output logic               hit,
  output logic [15:0]        line
);

  logic               valid_q, valid_d;
  logic [WORD_AW-1:0] tag_q, tag_d;
  logic [15:0]        line_q, line_d;

  assign hit  = CACHE_EN && valid_q && !flush && (tag_q == lookup_tag);
  assign line = line_q;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    line_d  = line_q;
    if (fill_en) begin
      valid_d = CACHE_EN;
      tag_d   = fill_tag;
      line_d  = fill_data;
    end else if (merge_en) begin
      line_d  = byte_merge(line_q, merge_a0, merge_byte);
    end
    if (flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and line are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    line_q <= line_d;
  end

endmodule

// File: rtl/sdram_cpu_bridge.sv
// sdram_cpu_bridge: 8-bit CPU strobe interface to one toggle req/ack SDRAM port.
//   clk, reset          : SDRAM clock, synchronous active-high reset
//   cpu_rd / cpu_wr     : single-cycle strobes (write wins if both)
//   cpu_a, cpu_din      : byte address, write data
//   cpu_dout            : read data, held until the next read completes
//   cpu_ready           : one-cycle pulse: read data valid or write accepted
//   cpu_busy            : strobes are ignored while high
//   cache_flush         : invalidate the one-word read cache
//   timeout_err         : sticky watchdog flag
//   mem                 : SDRAM controller port (master side)
// Reads hit a one-word cache when possible; writes are posted (cpu_ready the
// cycle after the strobe) and written through into the cache on a hit.
module sdram_cpu_bridge
  import sdram_pkg::*;
#(
  parameter bit         CACHE_EN       = 1'b1,
  parameter logic [9:0] TIMEOUT_CYCLES = 10'd1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_rd,
  input  logic               cpu_wr,
  input  logic [BYTE_AW-1:0] cpu_a,
  input  logic [7:0]         cpu_din,
  output logic [7:0]         cpu_dout,
  output logic               cpu_ready,
  output logic               cpu_busy,
  input  logic               cache_flush,
  output logic               timeout_err,
  sdram_cpu_bridge_if.master mem
);

  bridge_state_e      state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [WORD_AW-1:0] mem_a_q, mem_a_d;
  logic [1:0]         mem_ds_q, mem_ds_d;
  logic [15:0]        mem_d_q, mem_d_d;
  logic [7:0]         cpu_dout_q, cpu_dout_d;
  logic               cpu_ready_q, cpu_ready_d;
  logic               timeout_err_q, timeout_err_d;
  logic               lane_q, lane_d;
  logic [9:0]         wdog_q, wdog_d;
  logic [9:0]         wdog_next;

  logic               pending;
  logic               cache_hit;
  logic [15:0]        cache_line;
  logic               fill_en;
  logic               merge_en;

  // The controller ack mirrors req, so an access is outstanding while they differ.
  assign pending = (mem_req_q != mem.mem_ack);

  sdram_word_cache #(
    .CACHE_EN (CACHE_EN)
  ) u_cache (
    .clk        (clk),
    .reset      (reset),
    .lookup_tag (cpu_a[BYTE_AW-1:1]),
    .flush      (cache_flush),
    .fill_en    (fill_en),
    .fill_tag   (mem_a_q),
    .fill_data  (mem.mem_q),
    .merge_en   (merge_en),
    .merge_a0   (cpu_a[0]),
    .merge_byte (cpu_din),
    .hit        (cache_hit),
    .line       (cache_line)
  );

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_a_d       = mem_a_q;
    mem_ds_d      = mem_ds_q;
    mem_d_d       = mem_d_q;
    cpu_dout_d    = cpu_dout_q;
    cpu_ready_d   = 1'b0;
    timeout_err_d = timeout_err_q;
    lane_d        = lane_q;
    wdog_d        = wdog_q;
    fill_en       = 1'b0;
    merge_en      = 1'b0;
    wdog_next     = wdog_q + 10'd1;

    case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (cpu_wr) begin
          // A simultaneous read strobe is dropped.
          mem_a_d     = cpu_a[BYTE_AW-1:1];
          mem_we_d    = 1'b1;
          mem_ds_d    = lane_ds(cpu_a[0]);
          mem_d_d     = {cpu_din, cpu_din};
          mem_req_d   = ~mem_req_q;
          cpu_ready_d = 1'b1;
          merge_en    = cache_hit;
          state_d     = WR_WAIT;
        end else if (cpu_rd) begin
          if (cache_hit) begin
            cpu_dout_d  = byte_extract(cache_line, cpu_a[0]);
            cpu_ready_d = 1'b1;
          end else begin
            mem_a_d   = cpu_a[BYTE_AW-1:1];
            mem_we_d  = 1'b0;
            mem_ds_d  = 2'b11;
            mem_req_d = ~mem_req_q;
            lane_d    = cpu_a[0];
            state_d   = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        if (!pending) begin
          fill_en     = 1'b1;
          cpu_dout_d  = byte_extract(mem.mem_q, lane_q);
          cpu_ready_d = 1'b1;
          wdog_d      = '0;
          state_d     = IDLE;
        end else if (wdog_next == TIMEOUT_CYCLES) begin
          // Abandon the access: resync req to ack so the port looks idle again.
          timeout_err_d = 1'b1;
          mem_req_d     = mem.mem_ack;
          cpu_dout_d    = 8'hFF;
          cpu_ready_d   = 1'b1;
          wdog_d        = '0;
          state_d       = IDLE;
        end else begin
          wdog_d = wdog_next;
        end
      end

      WR_WAIT: begin
        if (!pending) begin
          wdog_d  = '0;
          state_d = IDLE;
        end else if (wdog_next == TIMEOUT_CYCLES) begin
          timeout_err_d = 1'b1;
          mem_req_d     = mem.mem_ack;
          wdog_d        = '0;
          state_d       = IDLE;
        end else begin
          wdog_d = wdog_next;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_a_q       <= '0;
      mem_ds_q      <= 2'b00;
      mem_d_q       <= '0;
      cpu_dout_q    <= 8'hFF;
      cpu_ready_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      lane_q        <= 1'b0;
      wdog_q        <= '0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_a_q       <= mem_a_d;
      mem_ds_q      <= mem_ds_d;
      mem_d_q       <= mem_d_d;
      cpu_dout_q    <= cpu_dout_d;
      cpu_ready_q   <= cpu_ready_d;
      timeout_err_q <= timeout_err_d;
      lane_q        <= lane_d;
      wdog_q        <= wdog_d;
    end
  end

  assign cpu_dout    = cpu_dout_q;
  assign cpu_ready   = cpu_ready_q;
  assign cpu_busy    = (state_q != IDLE);
  assign timeout_err = timeout_err_q;

  assign mem.mem_req = mem_req_q;
  assign mem.mem_we  = mem_we_q;
  assign mem.mem_a   = mem_a_q;
  assign mem.mem_ds  = mem_ds_q;
  assign mem.mem_d   = mem_d_q;

endmodule

// File: tb/tb_sdram_cpu_bridge.sv
// Directed bench for sdram_cpu_bridge: a cached instance and an uncached
// instance share the CPU stimulus; each has its own toy controller that acks
// 8 cycles after a req toggle (the cached one's ack can be withheld).
module tb_sdram_cpu_bridge;
  import sdram_pkg::*;

  localparam int ACK_DLY = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic        cache_flush = 1'b0;
  logic [23:0] cpu_a = '0;
  logic [7:0]  cpu_din = '0;

  logic [7:0]  cpu_dout, dout_nc;
  logic        cpu_ready, ready_nc;
  logic        cpu_busy, busy_nc;
  logic        timeout_err, terr_nc;

  logic [15:0] q_value = 16'hA55A;
  logic        hold_ack = 1'b0;

  int nvec = 0;
  int nerr = 0;
  int tog = 0;
  int tog_nc = 0;
  int cnt = 0;
  int cnt_nc = 0;
  logic prev_req = 1'b0;
  logic prev_req_nc = 1'b0;

  always #5 clk = ~clk;

  sdram_cpu_bridge_if bus ();
  sdram_cpu_bridge_if bus_nc ();

  sdram_cpu_bridge #(.CACHE_EN(1'b1), .TIMEOUT_CYCLES(10'd15)) dut (
    .clk(clk), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_a(cpu_a),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ready(cpu_ready), .cpu_busy(cpu_busy),
    .cache_flush(cache_flush), .timeout_err(timeout_err), .mem(bus)
  );

  sdram_cpu_bridge #(.CACHE_EN(1'b0), .TIMEOUT_CYCLES(10'd15)) dut_nc (
    .clk(clk), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_a(cpu_a),
    .cpu_din(cpu_din), .cpu_dout(dout_nc), .cpu_ready(ready_nc), .cpu_busy(busy_nc),
    .cache_flush(cache_flush), .timeout_err(terr_nc), .mem(bus_nc)
  );

  assign bus.mem_q    = q_value;
  assign bus_nc.mem_q = q_value;

  // Toy controllers: ack ACK_DLY cycles after seeing req != ack.
  always @(posedge clk) begin
    if (reset) begin
      bus.mem_ack <= 1'b0;
      cnt <= 0;
    end else if (bus.mem_req != bus.mem_ack && !hold_ack) begin
      if (cnt == ACK_DLY - 1) begin
        bus.mem_ack <= bus.mem_req;
        cnt <= 0;
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      bus_nc.mem_ack <= 1'b0;
      cnt_nc <= 0;
    end else if (bus_nc.mem_req != bus_nc.mem_ack) begin
      if (cnt_nc == ACK_DLY - 1) begin
        bus_nc.mem_ack <= bus_nc.mem_req;
        cnt_nc <= 0;
      end else begin
        cnt_nc <= cnt_nc + 1;
      end
    end
  end

  // Request toggle counters.
  always @(posedge clk) begin
    prev_req    <= bus.mem_req;
    prev_req_nc <= bus_nc.mem_req;
    if (!reset && bus.mem_req !== prev_req) tog <= tog + 1;
    if (!reset && bus_nc.mem_req !== prev_req_nc) tog_nc <= tog_nc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns number of negedges until cpu_ready is seen.
  task automatic cpu_read(input logic [23:0] a, input logic flush, output int lat);
    cpu_a = a;
    cpu_rd = 1'b1;
    cache_flush = flush;
    @(negedge clk);
    cpu_rd = 1'b0;
    cache_flush = 1'b0;
    lat = 1;
    while (cpu_ready !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (cpu_busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, cpu_busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int lat;
    int t0;
    int tn0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_a", bus.mem_a, 0);
    check("rst_mem_ds", bus.mem_ds, 0);
    check("rst_mem_d", bus.mem_d, 0);
    check("rst_cpu_dout", cpu_dout, 8'hFF);
    check("rst_cpu_ready", cpu_ready, 0);
    check("rst_cpu_busy", cpu_busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    reset = 1'b0;
    @(negedge clk);

    // Read miss 0x000100, controller returns A55A
    t0 = tog;
    tn0 = tog_nc;
    cpu_read(24'h000100, 1'b0, lat);
    check("miss_dout", cpu_dout, 8'h5A);
    check("miss_latency", lat, 10);
    check("miss_mem_ds", bus.mem_ds, 2'b11);
    check("miss_mem_we", bus.mem_we, 0);
    check("miss_mem_a", bus.mem_a, 23'h000080);
    @(negedge clk);
    check("miss_ready_pulse", cpu_ready, 0);
    check("miss_toggles", tog - t0, 1);
    check("nc_miss_toggles", tog_nc - tn0, 1);

    // Read 0x000101: hit, no toggle; uncached instance toggles
    t0 = tog;
    tn0 = tog_nc;
    cpu_read(24'h000101, 1'b0, lat);
    check("hit_dout", cpu_dout, 8'hA5);
    check("hit_latency", lat, 1);
    @(negedge clk);
    check("hit_ready_pulse", cpu_ready, 0);
    check("hit_toggles", tog - t0, 0);
    check("nc_hit_toggles", tog_nc - tn0, 1);
    repeat (12) @(negedge clk);

    // Posted write 0x3C to 0x000101, write-through into cache
    t0 = tog;
    cpu_a = 24'h000101;
    cpu_din = 8'h3C;
    cpu_wr = 1'b1;
    @(negedge clk);
    cpu_wr = 1'b0;
    check("wr_ready", cpu_ready, 1);
    check("wr_busy", cpu_busy, 1);
    check("wr_mem_ds", bus.mem_ds, 2'b10);
    check("wr_mem_d", bus.mem_d, 16'h3C3C);
    check("wr_mem_we", bus.mem_we, 1);
    check("wr_mem_a", bus.mem_a, 23'h000080);
    @(negedge clk);
    check("wr_ready_pulse", cpu_ready, 0);
    check("wr_busy_hold", cpu_busy, 1);
    wait_idle("wr_idle");
    check("wr_toggles", tog - t0, 1);
    t0 = tog;
    cpu_read(24'h000101, 1'b0, lat);
    check("wr_reread_dout", cpu_dout, 8'h3C);
    check("wr_reread_latency", lat, 1);
    cpu_read(24'h000100, 1'b0, lat);
    check("wr_lowbyte_dout", cpu_dout, 8'h5A);
    check("wr_lowbyte_latency", lat, 1);
    @(negedge clk);
    check("wr_reread_toggles", tog - t0, 0);
    repeat (12) @(negedge clk);

    // Simultaneous rd+wr at 0x000200, then a strobe while busy
    t0 = tog;
    cpu_a = 24'h000200;
    cpu_din = 8'h77;
    cpu_rd = 1'b1;
    cpu_wr = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    check("rdwr_mem_we", bus.mem_we, 1);
    check("rdwr_mem_ds", bus.mem_ds, 2'b01);
    check("rdwr_mem_a", bus.mem_a, 23'h000100);
    check("rdwr_mem_d", bus.mem_d, 16'h7777);
    check("rdwr_ready", cpu_ready, 1);
    cpu_a = 24'h000300;
    cpu_rd = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0;
    check("busy_strobe_mem_a", bus.mem_a, 23'h000100);
    wait_idle("rdwr_idle");
    repeat (3) @(negedge clk);
    check("rdwr_toggles", tog - t0, 1);
    check("rdwr_no_ready", cpu_ready, 0);
    repeat (10) @(negedge clk);

    // Flush, then re-read the cached word
    q_value = 16'h1234;
    t0 = tog;
    cache_flush = 1'b1;
    @(negedge clk);
    cache_flush = 1'b0;
    cpu_read(24'h000100, 1'b0, lat);
    check("flush_dout", cpu_dout, 8'h34);
    check("flush_latency", lat, 10);
    @(negedge clk);
    check("flush_toggles", tog - t0, 1);

    // Read in the same cycle as a flush is a miss
    t0 = tog;
    cpu_read(24'h000101, 1'b1, lat);
    check("rdflush_dout", cpu_dout, 8'h12);
    check("rdflush_latency", lat, 10);
    @(negedge clk);
    check("rdflush_toggles", tog - t0, 1);
    cpu_read(24'h000101, 1'b0, lat);
    check("refill_hit_latency", lat, 1);
    check("refill_hit_dout", cpu_dout, 8'h12);
    repeat (12) @(negedge clk);

    // Watchdog: ack withheld during a read
    hold_ack = 1'b1;
    cpu_read(24'h000400, 1'b0, lat);
    check("wdog_latency", lat, 16);
    check("wdog_timeout_err", timeout_err, 1);
    check("wdog_dout", cpu_dout, 8'hFF);
    check("wdog_req_resync", bus.mem_req, bus.mem_ack);
    check("wdog_busy", cpu_busy, 0);
    @(negedge clk);
    check("wdog_ready_pulse", cpu_ready, 0);
    check("wdog_sticky", timeout_err, 1);
    hold_ack = 1'b0;

    // Reset clears the sticky flag
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst2_timeout_err", timeout_err, 0);
    check("rst2_cpu_dout", cpu_dout, 8'hFF);
    check("rst2_mem_req", bus.mem_req, 0);
    reset = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
